ff_write_arbiter: RTL
=====================

Name: ff_write_arbiter

Overview:
- Round-robin arbiter that shares one enable-gated D register (1/2/4-bit flip-flop bank with clk, reset, eneable, D, Q) among NREQ requesters.
- Each transaction runs three phases: grant, a one-cycle write strobe, then a read-back check of Q.
- The block sits between requester logic and the register bank, and is the only driver of the bank's eneable and D.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, data width of the shared register (1, 2 or 4 in current use).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester write request; held high until the matching ack.
- wdata  input  NREQ*W  packed write data; requester i uses bits [i*W +: W].
- q  input  W  Q output of the shared register, for read-back.
- eneable  output  1  write enable to the shared register.
- d  output  W  data to the shared register's D input.
- gnt  output  NREQ  one-hot grant, high for the whole transaction.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with ack, when read-back mismatches.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, ptr=0, eneable=0, d=0, gnt=0, ack=0, err=0, busy=0, latched data=0.
- All outputs are decoded from registered state, winner index and latched data. There are no combinational paths from req to outputs.
- State IDLE (eneable=0, gnt=0):
  - On a clk edge with any req bit high, pick the winner by round-robin.
  - Search order: ptr, ptr+1, ..., wrapping modulo NREQ; the first high req bit wins.
  - Latch the winner index and wdata[winner] on that edge, then go to WRITE.
- State WRITE, exactly 1 cycle: eneable=1, d=latched data, gnt[winner]=1, busy=1. Go to CHECK.
- State CHECK, exactly 1 cycle:
  - eneable=0; d and gnt are held.
  - ack[winner]=1.
  - err=1 iff q != latched data.
  - On exit, ptr = (winner+1) mod NREQ. Go to IDLE.
- Latency: req sampled at edge k gives WRITE in cycle k+1 and ack in cycle k+2. Issue interval is 3 cycles per transaction.
- Back-to-back: a requester still asserting req in the cycle after its ack is eligible again, but it has lowest priority because of the ptr update.
- Changes to req or wdata during WRITE/CHECK are ignored. The transaction completes with the latched data even if the winner drops req early.
- Contention: with several req bits high in IDLE, exactly one is served per transaction. Under continuous full load, service order rotates i, i+1, ..., with no starvation. Worst-case wait is NREQ transactions.
- ptr wraps from NREQ-1 to 0.
- Reset asserted mid-WRITE drops eneable within the same cycle. The register bank is reset in parallel, so no ack or err is produced for the aborted transaction.
- With req all-zero, the block stays in IDLE and holds d at its last value.

Test Plan:
- Single request, NREQ=4, W=4: reset, then req=0001 with wdata[3:0]=4'b0011 → eneable=1 for exactly one cycle with d=0011, gnt=0001. Next cycle ack=0001, q=0011, err=0, then busy falls.
- Full contention: req=1111, wdata per requester = 1,2,3,4 → grant order 0,1,2,3,0 across consecutive 3-cycle transactions. The register sees 0001, 0010, 0011, 0100 in that order.
- Rotation from ptr: after serving requester 2, drive req=0101 → requester 0 wins via wrap (ptr=3 finds nothing at 3, wraps to 0). Next transaction goes to requester 2.
- Read-back fault: force q to 0000 during CHECK of a 4'b1100 write → err=1 and ack pulse together for one cycle. State returns to IDLE and the next request is served normally.
- Reset mid-operation: assert reset during WRITE → eneable, gnt, busy go to 0 at once with no ack. After release, req=1000 is served first by round-robin from ptr=0 (requesters 0–2 idle).
- Early drop: winner lowers req during WRITE and changes wdata → d keeps the latched value, and ack still pulses in CHECK.

Source files
------------

// File: rtl/ff_write_arbiter.sv
// ff_write_arbiter
//   Round-robin arbiter that owns the enable/data inputs of one shared
//   enable-gated D register bank and multiplexes it among NREQ requesters.
//   Every transaction is IDLE (arbitrate, latch) -> WRITE (one-cycle strobe)
//   -> CHECK (ack plus read-back compare of the bank's Q).
//
// Parameters
//   NREQ : number of requesters (2..8)
//   W    : data width of the shared register
//
// Ports
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high reset
//   req     : per-requester write request, held until matching ack
//   wdata   : packed write data, requester i owns [i*W +: W]
//   q       : Q of the shared register, used for read-back
//   eneable : write enable to the shared register (high in WRITE only)
//   d       : data to the shared register's D input (latched data)
//   gnt     : one-hot grant, high in WRITE and CHECK
//   ack     : one-hot completion pulse in CHECK
//   err     : read-back mismatch pulse, coincident with ack
//   busy    : high whenever not IDLE
module ff_write_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] wdata,
   input  logic [W-1:0]      q,
   output logic              eneable,
   output logic [W-1:0]      d,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic              err,
   output logic              busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] win_q, win_d;
   logic [W-1:0]  data_q, data_d;

   // Arbitration results (IDLE only)
   logic          found;
   logic [IW-1:0] pick_idx;
   logic [IW:0]   cand;
   logic [W-1:0]  pick_data;
   logic [NREQ-1:0] win_oh;

   // Round-robin search starting at ptr_q. The candidate is formed one bit
   // wider than the index so the modulo-NREQ wrap is exact for
   // non-power-of-two NREQ.
   always_comb begin
      found    = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (!found && req[cand[IW-1:0]]) begin
            found    = 1'b1;
            pick_idx = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      pick_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_idx == IW'(i)) begin
            pick_data = wdata[i*W +: W];
         end
      end
   end

   always_comb begin
      win_oh = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         win_oh[i] = (win_q == IW'(i));
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      data_d  = data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               win_d   = pick_idx;
               data_d  = pick_data;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            // Winner drops to lowest priority for the next search.
            if (win_q == IW'(NREQ-1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = win_q + IW'(1);
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         data_q  <= data_d;
      end
   end

   // Outputs decoded from registered state only (q feeds err in CHECK).
   always_comb begin
      eneable = 1'b0;
      gnt     = '0;
      ack     = '0;
      err     = 1'b0;
      busy    = 1'b0;
      d       = data_q;
      unique case (state_q)
         ST_WRITE: begin
            eneable = 1'b1;
            gnt     = win_oh;
            busy    = 1'b1;
         end
         ST_CHECK: begin
            gnt  = win_oh;
            ack  = win_oh;
            err  = (q != data_q);
            busy = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
